// File: rtl/fb_arbiter.sv
// Frame-buffer port arbiter: shares one single-port synchronous RAM between the
// pixel-slot read pipeline (always wins) and a held-request game-logic writer.
module fb_arbiter #(
    parameter int H_RES  = 160,
    parameter int V_RES  = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clk_100m,
    input  logic              rst,
    input  logic              pix_tick,
    input  logic [7:0]        rd_x,
    input  logic [6:0]        rd_y,
    input  logic              rd_active,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              overrun,
    output logic [1:0]        rd_state
);

    // Handshakes: wr_req is level-held by the writer until it sees the one-cycle
    // wr_ack (performed or dropped); rd_valid is a one-cycle strobe with no back-pressure.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } rd_state_t;

    localparam logic [31:0] FB_SIZE = 32'(H_RES * V_RES);

    rd_state_t         state;
    logic              blank;
    logic [ADDR_W-1:0] rd_lin;
    logic              rd_vis;
    logic              tick_ok;
    logic              rd_go;
    logic              wr_go;
    logic              wr_in_range;

    generate
        if (H_RES == 160) begin : g_shift_add
            assign rd_lin = (ADDR_W'(rd_y) << 7) + (ADDR_W'(rd_y) << 5) + ADDR_W'(rd_x);
        end else begin : g_generic
            assign rd_lin = ADDR_W'(32'(rd_y) * 32'(H_RES) + 32'(rd_x));
        end
    endgenerate

    // Off-screen coordinates behave exactly like a blanking slot.
    assign rd_vis      = rd_active && (32'(rd_x) < 32'(H_RES)) && (32'(rd_y) < 32'(V_RES));
    assign tick_ok     = pix_tick && ((state == IDLE) || (state == DELIVER));
    assign rd_go       = tick_ok && rd_vis;
    assign wr_go       = !rd_go && wr_req && !wr_ack;
    assign wr_in_range = 32'(wr_addr) < FB_SIZE;
    assign rd_state    = state;

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            blank     <= 1'b0;
            rd_data   <= 8'h00;
            rd_valid  <= 1'b0;
            wr_ack    <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= 8'h00;
            overrun   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            wr_ack   <= 1'b0;
            mem_we   <= 1'b0;

            if (pix_tick && ((state == ISSUE) || (state == WAIT))) begin
                overrun <= 1'b1;
            end

            // Memory port: read issue beats a write grant; a dropped write only acks.
            if (rd_go) begin
                mem_addr <= rd_lin;
            end else if (wr_go) begin
                wr_ack <= 1'b1;
                if (wr_in_range) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= wr_addr;
                    mem_wdata <= wr_data;
                end
            end

            case (state)
                IDLE: begin
                    if (tick_ok) begin
                        state <= ISSUE;
                        blank <= !rd_vis;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // RAM output here reflects the address presented in ISSUE.
                    rd_data  <= blank ? 8'h00 : mem_rdata;
                    rd_valid <= 1'b1;
                    state    <= DELIVER;
                end
                DELIVER: begin
                    if (tick_ok) begin
                        state <= ISSUE;
                        blank <= !rd_vis;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: table of per-cycle vectors plus hand-written
// sequences for write/read interleave, overrun and reset-in-flight.
module tb_fb_arbiter;

    localparam int ADDR_W = 15;

    logic              clk_100m = 1'b0;
    logic              rst;
    logic              pix_tick;
    logic [7:0]        rd_x;
    logic [6:0]        rd_y;
    logic              rd_active;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              overrun;
    logic [1:0]        rd_state;

    int checks = 0;
    int errors = 0;

    fb_arbiter #(.H_RES(160), .V_RES(120), .ADDR_W(ADDR_W)) dut (
        .clk_100m (clk_100m),
        .rst      (rst),
        .pix_tick (pix_tick),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .rd_active(rd_active),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .overrun  (overrun),
        .rd_state (rd_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_100m = ~clk_100m;

    // ---------------- RAM model ----------------
    function automatic logic [7:0] pat(int a);
        if (a == 3205) return 8'hE3;
        if (a == 1603) return 8'h5A;
        return 8'(a * 7 + 3);
    endfunction

    logic [7:0] ram [0:32767];
    logic       loaded = 1'b0;

    always @(posedge clk_100m) begin
        if (!loaded) begin
            for (int i = 0; i < 32768; i++) ram[i] <= pat(i);
            loaded    <= 1'b1;
            mem_rdata <= 8'h00;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_100m);
        #1;
    endtask

    task automatic idle_inputs();
        pix_tick  = 1'b0;
        rd_x      = 8'd0;
        rd_y      = 7'd0;
        rd_active = 1'b0;
        wr_req    = 1'b0;
        wr_addr   = '0;
        wr_data   = 8'h00;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " rd_data"},   32'(rd_data),   32'h0);
        chk({tag, " rd_valid"},  32'(rd_valid),  32'h0);
        chk({tag, " wr_ack"},    32'(wr_ack),    32'h0);
        chk({tag, " mem_addr"},  32'(mem_addr),  32'h0);
        chk({tag, " mem_we"},    32'(mem_we),    32'h0);
        chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'h0);
        chk({tag, " overrun"},   32'(overrun),   32'h0);
        chk({tag, " state"},     32'(rd_state),  32'h0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic              tick;
        logic [7:0]        x;
        logic [6:0]        y;
        logic              act;
        logic              wreq;
        logic [ADDR_W-1:0] waddr;
        logic [7:0]        wdata;
        logic              e_valid;
        logic [7:0]        e_data;
        logic              e_ack;
        logic              e_we;
        logic [ADDR_W-1:0] e_addr;
    } vec_t;

    function automatic vec_t mk(int tick, int x, int y, int act, int wreq, int waddr, int wdata,
                                int ev, int ed, int ea, int ew, int eaddr);
        vec_t m;
        m.tick = 1'(tick);   m.x = 8'(x);         m.y = 7'(y);       m.act = 1'(act);
        m.wreq = 1'(wreq);   m.waddr = 15'(waddr); m.wdata = 8'(wdata);
        m.e_valid = 1'(ev);  m.e_data = 8'(ed);    m.e_ack = 1'(ea);  m.e_we = 1'(ew);
        m.e_addr = 15'(eaddr);
        return m;
    endfunction

    vec_t vecs [32];

    // ---------------- scoreboard state ----------------
    logic [ADDR_W-1:0] exp_q   [$];
    logic [7:0]        expd_q  [$];
    logic [7:0]        rexp_q  [$];
    int                wq_addr [$];
    logic [7:0]        wq_data [$];

    initial begin
        int vcnt;
        int acnt;
        int wcnt;
        int since;

        //   tick  x   y  act wreq waddr wdata | valid data ack we addr
        vecs[0]  = mk(1, 5, 20, 1, 0, 0, 0,         0, 'h00, 0, 0, 3205);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0,          0, 'h00, 0, 0, 3205);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0,          1, 'hE3, 0, 0, 3205);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0,          0, 'hE3, 0, 0, 3205);
        vecs[4]  = mk(1, 5, 20, 1, 1, 100, 'h1C,    0, 'hE3, 0, 0, 3205);
        vecs[5]  = mk(0, 0, 0, 0, 1, 100, 'h1C,     0, 'hE3, 1, 1, 100);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0,          1, 'hE3, 0, 0, 100);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0,          0, 'hE3, 0, 0, 100);
        vecs[8]  = mk(1, 100, 0, 1, 0, 0, 0,        0, 'hE3, 0, 0, 100);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0,          0, 'hE3, 0, 0, 100);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0,          1, 'h1C, 0, 0, 100);
        vecs[11] = mk(1, 5, 20, 0, 0, 0, 0,         0, 'h1C, 0, 0, 100);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0,          0, 'h1C, 0, 0, 100);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0,          1, 'h00, 0, 0, 100);
        vecs[14] = mk(1, 160, 0, 1, 0, 0, 0,        0, 'h00, 0, 0, 100);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0,          0, 'h00, 0, 0, 100);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0,          1, 'h00, 0, 0, 100);
        vecs[17] = mk(1, 0, 120, 1, 0, 0, 0,        0, 'h00, 0, 0, 100);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0,          0, 'h00, 0, 0, 100);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 0,          1, 'h00, 0, 0, 100);
        vecs[20] = mk(0, 0, 0, 0, 1, 19200, 'hFF,   0, 'h00, 1, 0, 100);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0,          0, 'h00, 0, 0, 100);
        vecs[22] = mk(1, 3, 10, 1, 0, 0, 0,         0, 'h00, 0, 0, 1603);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 0,          0, 'h00, 0, 0, 1603);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 0,          1, 'h5A, 0, 0, 1603);
        vecs[25] = mk(0, 0, 0, 0, 0, 0, 0,          0, 'h5A, 0, 0, 1603);
        vecs[26] = mk(1, 5, 20, 1, 0, 0, 0,         0, 'h5A, 0, 0, 3205);
        vecs[27] = mk(0, 0, 0, 0, 0, 0, 0,          0, 'h5A, 0, 0, 3205);
        vecs[28] = mk(0, 0, 0, 0, 0, 0, 0,          1, 'hE3, 0, 0, 3205);
        vecs[29] = mk(1, 3, 10, 1, 0, 0, 0,         0, 'hE3, 0, 0, 1603);
        vecs[30] = mk(0, 0, 0, 0, 0, 0, 0,          0, 'hE3, 0, 0, 1603);
        vecs[31] = mk(0, 0, 0, 0, 0, 0, 0,          1, 'h5A, 0, 0, 1603);

        // ---- reset ----
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        // ---- table ----
        for (int i = 0; i < 32; i++) begin
            pix_tick  = vecs[i].tick;
            rd_x      = vecs[i].x;
            rd_y      = vecs[i].y;
            rd_active = vecs[i].act;
            wr_req    = vecs[i].wreq;
            wr_addr   = vecs[i].waddr;
            wr_data   = vecs[i].wdata;
            step();
            chk($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d rd_data", i),  32'(rd_data),  32'(vecs[i].e_data));
            chk($sformatf("vec%0d wr_ack", i),   32'(wr_ack),   32'(vecs[i].e_ack));
            chk($sformatf("vec%0d mem_we", i),   32'(mem_we),   32'(vecs[i].e_we));
            chk($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
            chk($sformatf("vec%0d overrun", i),  32'(overrun),  32'h0);
        end

        // ---- held writer with three queued writes, pix_tick every 4 cycles ----
        wq_addr = '{19000, 19001, 19002};
        wq_data = '{8'hA1, 8'hB2, 8'hC3};
        exp_q   = '{15'd19000, 15'd19001, 15'd19002};
        expd_q  = '{8'hA1, 8'hB2, 8'hC3};
        acnt = 0; wcnt = 0; since = 0;
        for (int c = 0; c < 40; c++) begin
            pix_tick  = (c % 4 == 0);
            rd_x      = 8'(10 + c);
            rd_y      = 7'(c / 4);
            rd_active = 1'b1;
            if (pix_tick) rexp_q.push_back(pat((c / 4) * 160 + 10 + c));
            wr_req = (wq_addr.size() > 0);
            if (wr_req) begin
                wr_addr = 15'(wq_addr[0]);
                wr_data = wq_data[0];
            end
            step();
            if (wr_req) since++;
            if (mem_we) begin
                wcnt++;
                if (exp_q.size() > 0) begin
                    chk($sformatf("stream write%0d addr", wcnt), 32'(mem_addr), 32'(exp_q.pop_front()));
                    chk($sformatf("stream write%0d data", wcnt), 32'(mem_wdata), 32'(expd_q.pop_front()));
                end else begin
                    chk("stream extra write", 32'(mem_addr), 32'hFFFF_FFFF);
                end
            end
            if (wr_ack) begin
                acnt++;
                chk($sformatf("stream grant gap%0d", acnt), 32'(since <= 4), 32'h1);
                since = 0;
                if (wq_addr.size() > 0) begin
                    void'(wq_addr.pop_front());
                    void'(wq_data.pop_front());
                end
            end
            if (rd_valid) begin
                if (rexp_q.size() > 0) chk($sformatf("stream read c%0d", c), 32'(rd_data), 32'(rexp_q.pop_front()));
                else chk("stream extra rd_valid", 32'(rd_valid), 32'h0);
            end
        end
        idle_inputs();
        chk("stream ack count", 32'(acnt), 32'd3);
        chk("stream write count", 32'(wcnt), 32'd3);
        chk("stream reads pending", 32'(rexp_q.size()), 32'd0);
        chk("stream overrun", 32'(overrun), 32'h0);

        // read back one written pixel: 118*160+120 = 19000
        pix_tick = 1'b1; rd_x = 8'd120; rd_y = 7'd118; rd_active = 1'b1;
        step();
        chk("readback addr", 32'(mem_addr), 32'd19000);
        idle_inputs();
        step();
        step();
        chk("readback valid", 32'(rd_valid), 32'h1);
        chk("readback data", 32'(rd_data), 32'hA1);
        step();
        step();

        // ---- overrun: pix_tick at T and T+2 ----
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            pix_tick  = (i == 0 || i == 2);
            rd_x      = 8'd5;
            rd_y      = 7'd20;
            rd_active = 1'b1;
            step();
            if (rd_valid) begin
                vcnt++;
                chk("overrun read data", 32'(rd_data), 32'hE3);
                chk("overrun read latency", 32'(i), 32'd2);
            end
            if (i == 1) chk("overrun before", 32'(overrun), 32'h0);
            if (i >= 2) chk($sformatf("overrun sticky%0d", i), 32'(overrun), 32'h1);
        end
        idle_inputs();
        chk("overrun valid count", 32'(vcnt), 32'd1);

        // ---- reset mid-read ----
        pix_tick = 1'b1; rd_x = 8'd3; rd_y = 7'd10; rd_active = 1'b1;
        step();
        idle_inputs();
        rst = 1'b1;
        #1;
        chk_all_zero("async rst");
        step();
        step();
        rst = 1'b0;
        vcnt = 0; acnt = 0; wcnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            vcnt += int'(rd_valid);
            acnt += int'(wr_ack);
            wcnt += int'(mem_we);
        end
        chk("rst read valid", 32'(vcnt), 32'd0);
        chk("rst read ack", 32'(acnt), 32'd0);
        chk("rst read we", 32'(wcnt), 32'd0);

        // ---- reset mid-write ----
        wr_req = 1'b1; wr_addr = 15'd50; wr_data = 8'h77;
        #2;
        rst = 1'b1;
        #1;
        wr_req = 1'b0;
        step();
        rst = 1'b0;
        acnt = 0; wcnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            acnt += int'(wr_ack);
            wcnt += int'(mem_we);
        end
        chk("rst write ack", 32'(acnt), 32'd0);
        chk("rst write we", 32'(wcnt), 32'd0);

        // ---- first pix_tick after release ----
        pix_tick = 1'b1; rd_x = 8'd5; rd_y = 7'd20; rd_active = 1'b1;
        step();
        chk("post rst addr", 32'(mem_addr), 32'd3205);
        chk("post rst valid T+1", 32'(rd_valid), 32'h0);
        idle_inputs();
        step();
        chk("post rst valid T+2", 32'(rd_valid), 32'h0);
        step();
        chk("post rst valid T+3", 32'(rd_valid), 32'h1);
        chk("post rst data", 32'(rd_data), 32'hE3);
        chk("post rst overrun", 32'(overrun), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
